// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM state encoding and the
// bit-period helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

  // Clocks per serial bit (integer division, caller guarantees >= 4).
  function automatic int uart_bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..P_BIT_PERIOD-1 and wraps, with a synchronous clear.
// mid_tick marks the half-bit point, end_tick the last clock of a bit period.
module uart_baud_cnt #(
  parameter int P_BIT_PERIOD = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_mid_tick,
  output logic o_end_tick
);

  localparam int CW = (P_BIT_PERIOD > 1) ? $clog2(P_BIT_PERIOD) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(P_BIT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(P_BIT_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_mid_tick = (cnt == MID_CNT);
  assign o_end_tick = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, finds the start bit, samples every
// bit at mid-period and reports each frame as a one-cycle valid pulse with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_rx_parity_err,
  output logic                         o_rx_frame_err,
  output logic [2:0]                   o_rx_state
);

  localparam int N          = uart_bit_period(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam int HAS_PARITY = (P_UART_CHECK != UART_CHECK_NONE) ? 1 : 0;
  localparam int FRAME_BITS = P_UART_DATA_WIDTH + HAS_PARITY + P_UART_STOP_WIDTH;
  localparam int BW         = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(P_UART_DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(P_UART_STOP_WIDTH - 1);
  // XOR of data and parity bit that a clean frame must produce.
  localparam logic PAR_TARGET = (P_UART_CHECK == UART_CHECK_ODD);

  logic rx_meta, rx_s, rx_d, rx_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall = rx_d & ~rx_s;

  uart_rx_state_t               state;
  logic [BW-1:0]                bit_cnt;
  logic [P_UART_DATA_WIDTH-1:0] shift_q;
  logic                         par_err_q;
  logic                         frame_err_q;
  logic                         baud_clear, mid_tick, end_tick;

  // Held clear while idle so START begins at zero; the counter wraps by itself
  // on every other bit-to-bit transition, so only START->DATA/IDLE needs a clear.
  assign baud_clear = (state == RX_IDLE) || (state == RX_START && mid_tick);

  uart_baud_cnt #(
    .P_BIT_PERIOD (N)
  ) u_baud_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (baud_clear),
    .o_mid_tick (mid_tick),
    .o_end_tick (end_tick)
  );

  // o_user_rx_valid is a one-cycle strobe with no ready: the consumer must take
  // o_user_rx_data and the error flags in that cycle; flags are 0 otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= RX_IDLE;
      bit_cnt         <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      o_user_rx_data  <= '0;
      o_user_rx_valid <= 1'b0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
    end else begin
      o_user_rx_valid <= 1'b0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          bit_cnt     <= '0;
          par_err_q   <= 1'b0;
          frame_err_q <= 1'b0;
          if (rx_fall) state <= RX_START;
        end
        RX_START: begin
          if (mid_tick) state <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (end_tick) begin
            shift_q <= {rx_s, shift_q[P_UART_DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (HAS_PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (end_tick) begin
            par_err_q <= ((^shift_q) ^ rx_s) != PAR_TARGET;
            state     <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (end_tick) begin
            if (!rx_s) frame_err_q <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              state           <= RX_IDLE;
              o_user_rx_valid <= 1'b1;
              o_user_rx_data  <= shift_q;
              o_rx_parity_err <= par_err_q;
              o_rx_frame_err  <= frame_err_q | ~rx_s;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four receivers (8N1, 8O1, 8E1, 8N2) share a bit-accurate
// serial driver; received frames are matched against frames the bench built itself.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int N      = 16;
  localparam int CFG_CHECK [4] = '{0, 1, 2, 0};
  localparam int CFG_STOP  [4] = '{1, 1, 1, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       rx_line = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [3:0] line_w;
  logic [3:0] valid_w, perr_w, ferr_w;
  logic [7:0] data_w  [4];
  logic [2:0] state_w [4];

  always_comb begin
    for (int k = 0; k < 4; k++) line_w[k] = (sel == 2'(k)) ? rx_line : 1'b1;
  end

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_n1 (
    .i_clk(clk), .i_rst(i_rst), .i_uart_rx(line_w[0]), .o_user_rx_data(data_w[0]),
    .o_user_rx_valid(valid_w[0]), .o_rx_parity_err(perr_w[0]), .o_rx_frame_err(ferr_w[0]),
    .o_rx_state(state_w[0]));
  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_odd (
    .i_clk(clk), .i_rst(i_rst), .i_uart_rx(line_w[1]), .o_user_rx_data(data_w[1]),
    .o_user_rx_valid(valid_w[1]), .o_rx_parity_err(perr_w[1]), .o_rx_frame_err(ferr_w[1]),
    .o_rx_state(state_w[1]));
  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_even (
    .i_clk(clk), .i_rst(i_rst), .i_uart_rx(line_w[2]), .o_user_rx_data(data_w[2]),
    .o_user_rx_valid(valid_w[2]), .o_rx_parity_err(perr_w[2]), .o_rx_frame_err(ferr_w[2]),
    .o_rx_state(state_w[2]));
  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) u_s2 (
    .i_clk(clk), .i_rst(i_rst), .i_uart_rx(line_w[3]), .o_user_rx_data(data_w[3]),
    .o_user_rx_valid(valid_w[3]), .o_rx_parity_err(perr_w[3]), .o_rx_frame_err(ferr_w[3]),
    .o_rx_state(state_w[3]));

  // ---------------- scoreboard ----------------
  // record = {dut index[1:0], frame_err, parity_err, data[7:0]}
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_valid_cyc = 0;
  logic stray_err = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (valid_w[k] === 1'b1) begin
        got_q.push_back({2'(k), ferr_w[k], perr_w[k], data_w[k]});
        last_valid_cyc <= cyc;
      end else if (perr_w[k] !== 1'b0 || ferr_w[k] !== 1'b0) begin
        stray_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_sb(input string tag);
    int budget = 4 * N;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      hold(1);
      budget--;
    end
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_frame"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model / driver ----------------
  // Parity bit that gives an odd (odd parity) or even (even parity) count of ones.
  function automatic logic good_parity(input int check, input logic [7:0] d);
    int ones = $countones(d);
    if (check == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic flip_par,
                            input logic stop_zero, input int low_after, input int gap);
    logic perr_exp;
    perr_exp = (CFG_CHECK[k] != 0) && flip_par;
    exp_q.push_back({k[1:0], stop_zero, perr_exp, d});
    sel = k[1:0];
    rx_line = 1'b0;
    hold(N);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      hold(N);
    end
    if (CFG_CHECK[k] != 0) begin
      rx_line = good_parity(CFG_CHECK[k], d) ^ flip_par;
      hold(N);
    end
    for (int i = 0; i < CFG_STOP[k]; i++) begin
      rx_line = ~stop_zero;
      hold(N);
    end
    if (low_after > 0) begin
      rx_line = 1'b0;
      hold(low_after);
    end
    rx_line = 1'b1;
    if (gap > 0) hold(gap);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0;
    logic [7:0] pat;
    logic [7:0] d;
    logic sz, fp;
    int gap;

    hold(3);
    chk("reset_valid", 32'(valid_w), 32'h0);
    chk("reset_data", 32'(data_w[0]), 32'h0);
    chk("reset_perr", 32'(perr_w), 32'h0);
    chk("reset_ferr", 32'(ferr_w), 32'h0);
    chk("reset_state", 32'(state_w[0]), 32'(RX_IDLE));
    i_rst = 1'b0;
    hold(2 * N);

    // 8N1 0xA5 with latency of 2+1+N/2+9N+1 = 156 clocks, +/-1
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 0, N);
    chk("a5_latency_ok", 32'((last_valid_cyc - t0) >= 155 && (last_valid_cyc - t0) <= 157), 32'h1);
    check_sb("a5");

    // 4-clock low glitch: no frame, back to idle, next frame clean
    sel = 2'd0;
    rx_line = 1'b0;
    hold(4);
    rx_line = 1'b1;
    hold(2 * N);
    chk("glitch_state", 32'(state_w[0]), 32'(RX_IDLE));
    check_sb("glitch");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0, N);
    check_sb("after_glitch");

    // reset in the middle of data bit 4 of 0x55
    pat = 8'h55;
    sel = 2'd0;
    rx_line = 1'b0;
    hold(N);
    for (int i = 0; i < 4; i++) begin
      rx_line = pat[i];
      hold(N);
    end
    rx_line = pat[4];
    hold(N / 2);
    i_rst = 1'b1;
    hold(1);
    chk("midrst_valid", 32'(valid_w[0]), 32'h0);
    chk("midrst_data", 32'(data_w[0]), 32'h0);
    chk("midrst_perr", 32'(perr_w[0]), 32'h0);
    chk("midrst_ferr", 32'(ferr_w[0]), 32'h0);
    chk("midrst_state", 32'(state_w[0]), 32'(RX_IDLE));
    i_rst = 1'b0;
    rx_line = 1'b1;
    hold(12 * N);
    check_sb("midrst");
    send_frame(0, 8'hAA, 1'b0, 1'b0, 0, N);
    check_sb("after_midrst");

    // odd then even parity on 0x07, good and bad parity bit each
    send_frame(1, 8'h07, 1'b0, 1'b0, 0, N);
    send_frame(1, 8'h07, 1'b1, 1'b0, 0, N);
    check_sb("odd_07");
    send_frame(2, 8'h07, 1'b0, 1'b0, 0, N);
    send_frame(2, 8'h07, 1'b1, 1'b0, 0, N);
    check_sb("even_07");

    // stop bit 0, line held low for 40 bit times: one frame, frame_err, nothing more
    send_frame(0, 8'h81, 1'b0, 1'b1, 40 * N, 2 * N);
    check_sb("stop_low");

    // two stop bits, back-to-back frames
    send_frame(3, 8'h00, 1'b0, 1'b0, 0, 0);
    send_frame(3, 8'hFF, 1'b0, 1'b0, 0, N);
    check_sb("two_stop");

    // random 8N1 traffic with occasional broken stop bits and random gaps
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      sz  = ($urandom_range(0, 3) == 0);
      gap = sz ? N + $urandom_range(0, N) : $urandom_range(0, 2 * N);
      send_frame(0, d, 1'b0, sz, 0, gap);
      check_sb("rand_8n1");
    end

    // random parity traffic on both parity receivers
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      fp = 1'($urandom_range(0, 1));
      send_frame(1 + (i % 2), d, fp, 1'b0, 0, $urandom_range(0, N));
      check_sb("rand_parity");
    end

    hold(2 * N);
    check_sb("tail");
    chk("flags_without_valid", 32'(stray_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
